// File: rtl/clkdiv_seq_ctrl.sv
// Reset/calibration sequencer for one Gowin CLKDIV, clocked by the divider's HCLKIN.
// Optional lock watchdog enabled by defining CLKDIV_SEQ_CTRL_TIMEOUT_EN.
module clkdiv_seq_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RST_HOLD_CYCLES    = 8,
  parameter int SETTLE_CYCLES      = 32,
  parameter int CALIB_GAP_CYCLES   = 4,
  parameter int CNT_W              = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic       hclkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart_req,
  input  logic       calib_req,
  output logic       calib_ack,
  output logic       div_resetn,
  output logic       div_calib,
  output logic       ready,
  output logic       busy,
  output logic [7:0] calib_count,
  output logic       lock_timeout
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_HOLD_RST, S_SETTLE, S_READY, S_CALIB, S_GAP
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_pending, w_pending_nxt;
  logic             w_abort;

  always_ff @(posedge hclkin) begin
    if (reset) begin
      r_state   <= S_WAIT_LOCK;
      r_timer   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_timer_nxt   = r_timer;
    w_pending_nxt = r_pending;
    w_abort       = (r_state != S_WAIT_LOCK) && (!pll_lock || restart_req);
    case (r_state)
      S_WAIT_LOCK: begin
        if (restart_req || !pll_lock)
          w_timer_nxt = '0;
        else if (r_timer == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          w_next      = S_HOLD_RST;
          w_timer_nxt = '0;
        end else
          w_timer_nxt = r_timer + 1'b1;
      end
      S_HOLD_RST: begin
        if (r_timer == CNT_W'(RST_HOLD_CYCLES - 1)) begin
          w_next      = S_SETTLE;
          w_timer_nxt = '0;
        end else
          w_timer_nxt = r_timer + 1'b1;
      end
      S_SETTLE: begin
        if (r_timer == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_next      = S_READY;
          w_timer_nxt = '0;
        end else
          w_timer_nxt = r_timer + 1'b1;
      end
      S_READY: begin
        if (calib_req || r_pending) begin
          w_next        = S_CALIB;
          w_pending_nxt = 1'b0;
        end
      end
      S_CALIB: begin
        w_next      = S_GAP;
        w_timer_nxt = '0;
        if (calib_req) w_pending_nxt = 1'b1;
      end
      S_GAP: begin
        // Last gap cycle hands a queued request straight to CALIB so
        // back-to-back pulses sit exactly CALIB_GAP_CYCLES+1 apart.
        if (r_timer == CNT_W'(CALIB_GAP_CYCLES - 1)) begin
          w_timer_nxt = '0;
          if (calib_req || r_pending) begin
            w_next        = S_CALIB;
            w_pending_nxt = 1'b0;
          end else
            w_next = S_READY;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          if (calib_req) w_pending_nxt = 1'b1;
        end
      end
      default: w_next = S_WAIT_LOCK;
    endcase
    if (w_abort) begin
      w_next        = S_WAIT_LOCK;
      w_timer_nxt   = '0;
      w_pending_nxt = 1'b0;
    end
  end

  // Outputs are registered images of the next state.
  always_ff @(posedge hclkin) begin
    if (reset) begin
      div_resetn  <= 1'b0;
      div_calib   <= 1'b0;
      calib_ack   <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      calib_count <= 8'd0;
    end else begin
      div_resetn <= (w_next == S_SETTLE) || (w_next == S_READY) ||
                    (w_next == S_CALIB)  || (w_next == S_GAP);
      ready      <= (w_next == S_READY) || (w_next == S_CALIB) || (w_next == S_GAP);
      busy       <= (w_next == S_CALIB) || (w_next == S_GAP);
      div_calib  <= (w_next == S_CALIB);
      calib_ack  <= (w_next == S_CALIB);
      if (w_next == S_CALIB) calib_count <= calib_count + 8'd1;
    end
  end

`ifdef CLKDIV_SEQ_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  always_ff @(posedge hclkin) begin
    if (reset) begin
      r_wd         <= '0;
      lock_timeout <= 1'b0;
    end else if (r_state != S_WAIT_LOCK) begin
      r_wd <= '0;
    end else if (r_wd != WD_W'(TIMEOUT_CYCLES)) begin
      r_wd <= r_wd + 1'b1;
      if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) lock_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign lock_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Bench for clkdiv_seq_ctrl: directed scenarios plus random traffic against a
// model built on "consecutive good-lock cycles" arithmetic and pulse timestamps.
module tb_clkdiv_seq_ctrl;
  localparam int LS  = 16;
  localparam int RH  = 8;
  localparam int ST  = 32;
  localparam int GAP = 4;
  localparam int TMO = 1024;

  logic       hclkin = 1'b0;
  logic       reset, pll_lock, restart_req, calib_req;
  logic       calib_ack, div_resetn, div_calib, ready, busy, lock_timeout;
  logic [7:0] calib_count;

  clkdiv_seq_ctrl #(
    .LOCK_STABLE_CYCLES(LS), .RST_HOLD_CYCLES(RH), .SETTLE_CYCLES(ST),
    .CALIB_GAP_CYCLES(GAP), .CNT_W(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .hclkin(hclkin), .reset(reset), .pll_lock(pll_lock),
    .restart_req(restart_req), .calib_req(calib_req), .calib_ack(calib_ack),
    .div_resetn(div_resetn), .div_calib(div_calib), .ready(ready), .busy(busy),
    .calib_count(calib_count), .lock_timeout(lock_timeout)
  );

  always #5 hclkin = ~hclkin;

  int n_chk = 0, n_pass = 0;

  // model state
  int m_k = 0, m_seq = 0, m_last = -1000, m_cnt = 0, m_wl = 0;
  bit m_pend = 0, m_pulse = 0, m_tmo = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, m_k);
  endtask

  task automatic model_edge();
    bit pr, pw;
    int since;
    m_k++;
    m_pulse = 0;
    if (reset) begin
      m_seq = 0; m_last = -1000; m_cnt = 0; m_wl = 0; m_pend = 0; m_tmo = 0;
      return;
    end
    pr = (m_seq >= LS + RH + ST);
    pw = (m_seq < LS);
    if (pw) begin
      if (m_wl < TMO) m_wl++;
      if (m_wl == TMO) m_tmo = 1;
    end else
      m_wl = 0;
    if (!pll_lock || restart_req) begin
      m_seq = 0; m_pend = 0; m_last = -1000;
    end else begin
      m_seq++;
      if (pr) begin
        since = m_k - m_last;
        if (since >= GAP + 1 && (calib_req || m_pend)) begin
          m_pulse = 1; m_last = m_k; m_pend = 0; m_cnt = (m_cnt + 1) % 256;
        end else if (since <= GAP && calib_req)
          m_pend = 1;
      end
    end
  endtask

  task automatic step(input bit lk, input bit rr, input bit cr);
    bit e_rdy;
    pll_lock = lk; restart_req = rr; calib_req = cr;
    @(posedge hclkin);
    model_edge();
    #1;
    e_rdy = (m_seq >= LS + RH + ST);
    chk("div_resetn", div_resetn, m_seq >= LS + RH);
    chk("ready", ready, e_rdy);
    chk("busy", busy, e_rdy && (m_k - m_last) <= GAP);
    chk("div_calib", div_calib, m_pulse);
    chk("calib_ack", calib_ack, m_pulse);
    chk("calib_count", calib_count, m_cnt);
`ifdef CLKDIV_SEQ_CTRL_TIMEOUT_EN
    chk("lock_timeout", lock_timeout, m_tmo);
`else
    chk("lock_timeout", lock_timeout, 0);
`endif
  endtask

  initial begin
    int t_rst, t_rdy, p0, p1, p2, c0;
    reset = 1'b1; pll_lock = 1'b0; restart_req = 1'b0; calib_req = 1'b0;
    repeat (3) step(0, 0, 0);
    reset = 1'b0;

    // bring-up with constant lock
    t_rst = 0; t_rdy = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0);
      if (div_resetn && t_rst == 0) t_rst = i;
      if (ready && t_rdy == 0) t_rdy = i;
    end
    chk("bringup_resetn_cycle", t_rst, 24);
    chk("bringup_ready_cycle", t_rdy, 56);

    // back-to-back: request sampled on 11 consecutive edges
    c0 = calib_count; p0 = 0; p1 = 0; p2 = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, i <= 11);
      if (div_calib) begin
        if (p0 == 0) p0 = i; else if (p1 == 0) p1 = i; else p2 = i;
      end
    end
    chk("b2b_count", calib_count, c0 + 3);
    chk("b2b_gap1", p1 - p0, GAP + 1);
    chk("b2b_gap2", p2 - p1, GAP + 1);

    // lock glitch: 10 good samples, one drop, then relock
    step(0, 0, 0);
    repeat (10) step(1, 0, 0);
    step(0, 0, 0);
    t_rst = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, 0);
      if (div_resetn && t_rst == 0) t_rst = i;
    end
    chk("glitch_resetn_cycle", t_rst, 24);

    // lock loss on the CALIB cycle
    repeat (30) step(1, 0, 0);
    step(1, 0, 1);
    chk("calib_pulse_seen", div_calib, 1);
    c0 = calib_count;
    step(0, 0, 0);
    chk("loss_resetn", div_resetn, 0);
    chk("loss_ready", ready, 0);
    chk("loss_calib", div_calib, 0);
    t_rdy = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0);
      if (ready && t_rdy == 0) t_rdy = i;
    end
    chk("relock_ready_cycle", t_rdy, 56);
    chk("relock_count_kept", calib_count, c0);

    // abort priority over a simultaneous request, then reset mid-SETTLE
    step(1, 1, 1);
    chk("abort_no_ack", calib_ack, 0);
    chk("abort_ready", ready, 0);
    repeat (30) step(1, 0, 0);
    reset = 1'b1;
    step(1, 0, 0);
    reset = 1'b0;
    chk("reset_count", calib_count, 0);
    chk("reset_resetn", div_resetn, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1999) == 0);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 499) == 0,
           $urandom_range(0, 2) == 0);
    end
    reset = 1'b0;

`ifdef CLKDIV_SEQ_CTRL_TIMEOUT_EN
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    repeat (TMO - 1) step(0, 0, 0);
    chk("wd_before_limit", lock_timeout, 0);
    step(0, 0, 0);
    chk("wd_at_limit", lock_timeout, 1);
    repeat (60) step(1, 0, 0);
    chk("wd_sticky", lock_timeout, 1);
`else
    chk("wd_disabled", lock_timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
